ram_arbiter2: RTL and testbench
===============================

Name: ram_arbiter2

Overview:
- Two-client round-robin arbiter and access sequencer for the team's single-port 16x4 RAM: combinational read, synchronous write on wen.
- Sits between two requesters (for example a CPU-side port and a DMA/display port) and the RAM's clk/wen/addr/din/qout pins.
- Grants one access per cycle.
- Returns read data with a one-cycle valid pulse.
- Can optionally zero-fill the RAM after reset.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  2  per-client access request; bit k = client k.
- we_i  input  2  per-client write-enable: 1 = write, 0 = read.
- addr_i  input  2*ADDR_W  per-client address; client k at [k*ADDR_W +: ADDR_W].
- wdata_i  input  2*DATA_W  per-client write data, packed the same way.
- gnt_o  output  2  one-hot grant; access performed in that cycle.
- rdata_o  output  DATA_W  registered read data of the last granted read.
- rvalid_o  output  2  one-cycle pulse, bit k: rdata_o belongs to client k.
- busy_o  output  1  high while the init sequence runs.
- ram_wen_o  output  1  to RAM wen.
- ram_addr_o  output  ADDR_W  to RAM addr.
- ram_din_o  output  DATA_W  to RAM din.
- ram_qout_i  input  DATA_W  from RAM qout (combinational read).

Behaviour:
- Reset (async, rst_n=0): gnt_o=0, rvalid_o=0, rdata_o=0, ram_wen_o=0, ram_addr_o=0, ram_din_o=0, last-served pointer=1 (client 0 wins the first tie), init counter=0.
- busy_o reset value is 1 with RAM_ARB_INIT_EN defined, 0 without it.
- FSM states: INIT, SERVE.
  - Reset enters INIT when RAM_ARB_INIT_EN is defined, otherwise SERVE.
  - INIT -> SERVE after the write to address 2**ADDR_W-1.
- SERVE grant rule (combinational in the same cycle as req_i):
  - If exactly one req_i bit is set, grant that client.
  - If both are set, grant the client that is not the last-served one.
  - If neither is set, gnt_o=0.
- RAM drive: ram_addr_o/ram_din_o/ram_wen_o mirror the granted client's addr/wdata/we. With no grant: ram_wen_o=0, ram_addr_o=0, ram_din_o=0.
- Pointer update: the last-served pointer updates on the clock edge of every granted cycle and holds otherwise.
- Write completion: a granted write completes at the edge ending the grant cycle.
- Read timing (latency 1): for a granted read, ram_qout_i is captured into rdata_o at the edge ending the grant cycle. rvalid_o[k] is high for exactly the following cycle.
- rdata_o holds its value until the next granted read.
- Writes never pulse rvalid_o.
- Requester contract:
  - Hold req/we/addr/wdata stable until gnt_o[k] is seen high.
  - Drop or change them the cycle after the grant.
  - Back-to-back grants to the same client are legal when the other client is idle.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1,...
- Read-after-write, same address, consecutive grants: the read returns the new data (the RAM write has committed by then).
- Reset mid-operation: all state returns to reset values immediately. Any in-flight rvalid is lost. An interrupted INIT restarts from address 0.

Optional Feature:
- Macro: RAM_ARB_INIT_EN.
- Defined:
  - After reset, INIT writes 0 to addresses 0..2**ADDR_W-1, one per cycle (16 cycles at the default), with ram_wen_o=1 and ram_addr_o=counter.
  - During INIT, gnt_o=0 and busy_o=1. Requests are held off, not dropped.
  - busy_o falls in the first SERVE cycle.
- Not defined:
  - No INIT state; busy_o is tied 0.
  - Arbitration begins the first cycle after reset release.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum (INIT, SERVE);
  - default ADDR_W/DATA_W localparams;
  - NUM_CLIENTS=2 constant.
- Natural sub-module: rr_arb2, the two-input round-robin grant logic with its last-served pointer flop.
- The top level holds the FSM, init counter, RAM muxing and read-return register.

Test Plan:
- Init enabled, release reset, no requests -> busy_o=1 for 16 cycles; addresses 0..15 written with 0; busy_o=0 after. A client-0 read of address 7 then returns rdata_o=0 with rvalid_o=01.
- Client 0 writes addr=3, data=0xA, then reads addr=3 -> gnt_o=01 twice. rvalid_o=01 one cycle after the second grant, rdata_o=0xA.
- Both clients request continuously right after reset (writes to 1 and 2) -> gnt_o sequence 01,10,01,10; never both, never a gap.
- Client 1 reads addr=5 in the same cycle client 0 writes addr=5 with 0x6 (pointer favours client 0) -> write first. Client 1 is granted next cycle and receives 0x6 with rvalid_o=10.
- rst_n pulsed low mid-INIT at counter=9 -> outputs return to reset values at once; after release, INIT restarts at address 0 and lasts the full 16 cycles.
- Single client 1 requests on 3 consecutive cycles, client 0 idle -> gnt_o=10 each cycle, three rvalid_o=10 pulses each one cycle later.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM arbiter.
// Holds the sequencer state enum and default RAM geometry.
package ram_arb_pkg;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int NUM_CLIENTS = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/ram_arbiter2_rr_arb2.sv
// Two-input round-robin grant logic with last-served pointer.
// Ports: clk, rst_n, i_en (allow grants), i_req[1:0], o_gnt[1:0] one-hot.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Last-served client; 1 at reset so client 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/ram_arbiter2.sv
// Two-client round-robin arbiter / sequencer for a single-port RAM.
// Ports: clk, rst_n, per-client req/we/addr/wdata in, gnt/rdata/rvalid
// out, busy_o, and the RAM pins ram_wen_o/ram_addr_o/ram_din_o/ram_qout_i.
// Define RAM_ARB_INIT_EN to zero-fill the RAM after every reset.
module ram_arbiter2
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CLIENTS-1:0]       req_i,
  input  logic [NUM_CLIENTS-1:0]       we_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata_i,
  output logic [NUM_CLIENTS-1:0]       gnt_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [NUM_CLIENTS-1:0]       rvalid_o,
  output logic                         busy_o,
  output logic                         ram_wen_o,
  output logic [ADDR_W-1:0]            ram_addr_o,
  output logic [DATA_W-1:0]            ram_din_o,
  input  logic [DATA_W-1:0]            ram_qout_i
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_W-1:0]        r_rdata;
  logic [NUM_CLIENTS-1:0]   r_rvalid;
  logic [NUM_CLIENTS-1:0]   w_gnt;
  logic [NUM_CLIENTS-1:0]   w_rd;
  logic                     w_en;
  logic                     w_wen;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_din;
`ifdef RAM_ARB_INIT_EN
  logic [ADDR_W-1:0]        r_cnt;
`endif

  // Grants are gated by rst_n so nothing reaches the RAM during reset.
  assign w_en = rst_n && (r_state == ST_SERVE);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_req (req_i),
    .o_gnt (w_gnt)
  );

  assign w_rd = w_gnt & ~we_i;

  always_comb begin
    w_state_nxt = r_state;
    w_wen       = 1'b0;
    w_addr      = '0;
    w_din       = '0;
`ifdef RAM_ARB_INIT_EN
    if (r_state == ST_INIT) begin
      w_wen  = rst_n;
      w_addr = r_cnt;
      if (r_cnt == {ADDR_W{1'b1}}) begin
        w_state_nxt = ST_SERVE;
      end
    end else
`endif
    begin
      unique case (1'b1)
        w_gnt[0]: begin
          w_wen  = we_i[0];
          w_addr = addr_i[0 +: ADDR_W];
          w_din  = wdata_i[0 +: DATA_W];
        end
        w_gnt[1]: begin
          w_wen  = we_i[1];
          w_addr = addr_i[ADDR_W +: ADDR_W];
          w_din  = wdata_i[DATA_W +: DATA_W];
        end
        default: begin
          w_wen  = 1'b0;
          w_addr = '0;
          w_din  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_ARB_INIT_EN
      r_state <= ST_INIT;
      r_cnt   <= '0;
`else
      r_state <= ST_SERVE;
`endif
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
`ifdef RAM_ARB_INIT_EN
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
      r_rvalid <= w_rd;
      if (|w_rd) begin
        r_rdata <= ram_qout_i;
      end
    end
  end

`ifdef RAM_ARB_INIT_EN
  assign busy_o = (r_state == ST_INIT);
`else
  assign busy_o = 1'b0;
`endif

  assign gnt_o      = w_gnt;
  assign rdata_o    = r_rdata;
  assign rvalid_o   = r_rvalid;
  assign ram_wen_o  = w_wen;
  assign ram_addr_o = w_addr;
  assign ram_din_o  = w_din;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed self-checking bench for ram_arbiter2 with a 16x4 RAM model.
// Covers both builds; RAM_ARB_INIT_EN adds the zero-fill checks.
module tb_ram_arbiter2;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_i;
  logic [1:0] we_i;
  logic [7:0] addr_i;
  logic [7:0] wdata_i;
  logic [1:0] gnt_o;
  logic [3:0] rdata_o;
  logic [1:0] rvalid_o;
  logic       busy_o;
  logic       ram_wen_o;
  logic [3:0] ram_addr_o;
  logic [3:0] ram_din_o;
  logic [3:0] ram_qout_i;

  logic [3:0] mem [16];

  int n_tests;
  int n_fail;

`ifdef RAM_ARB_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  ram_arbiter2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .busy_o     (busy_o),
    .ram_wen_o  (ram_wen_o),
    .ram_addr_o (ram_addr_o),
    .ram_din_o  (ram_din_o),
    .ram_qout_i (ram_qout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen_o) mem[ram_addr_o] <= ram_din_o;
  end
  assign ram_qout_i = mem[ram_addr_o];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".gnt"},    32'(gnt_o),      32'h0);
    chk({tag, ".rvalid"}, 32'(rvalid_o),   32'h0);
    chk({tag, ".rdata"},  32'(rdata_o),    32'h0);
    chk({tag, ".wen"},    32'(ram_wen_o),  32'h0);
    chk({tag, ".addr"},   32'(ram_addr_o), 32'h0);
    chk({tag, ".din"},    32'(ram_din_o),  32'h0);
    chk({tag, ".busy"},   32'(busy_o),     32'(BUSY_RST));
  endtask

`ifdef RAM_ARB_INIT_EN
  // Count busy cycles (bounded), check addresses walk 0..15 and grants
  // stay off; called mid-cycle right after reset release.
  task automatic wait_init();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) break;
      chk("init_addr", 32'(ram_addr_o), 32'(cnt));
      chk("init_gnt",  32'(gnt_o),      32'h0);
      cnt++;
      tick();
    end
    chk("init_len", 32'(cnt), 32'd16);
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 4'hF;
    rst_n   = 1'b1;
    req_i   = 2'b11;
    we_i    = 2'b11;
    addr_i  = 8'h00;
    wdata_i = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    req_i = 2'b00;
    rst_n = 1'b1;
    #1;

`ifdef RAM_ARB_INIT_EN
    wait_init();
    chk("busy_after", 32'(busy_o), 32'h0);
    for (int i = 0; i < 16; i++) chk("zero_fill", 32'(mem[i]), 32'h0);
`else
    chk("busy_tied", 32'(busy_o), 32'h0);
`endif

    // Both clients write continuously: 01,10,01,10.
    req_i   = 2'b11;
    we_i    = 2'b11;
    addr_i  = {4'h2, 4'h1};
    wdata_i = {4'hC, 4'h3};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("rr_norv", 32'(rvalid_o), 32'h0);
    end

    // Tie: client 0 (write 5<-6) wins, then client 1 reads 5.
    we_i    = 2'b01;
    addr_i  = {4'h5, 4'h5};
    wdata_i = {4'h0, 4'h6};
    #1;
    chk("raw_gnt0", 32'(gnt_o), 32'h1);
    chk("raw_wen",  32'(ram_wen_o), 32'h1);
    chk("raw_din",  32'(ram_din_o), 32'h6);
    tick();
    req_i = 2'b10;
    #1;
    chk("raw_gnt1", 32'(gnt_o), 32'h2);
    chk("raw_addr", 32'(ram_addr_o), 32'h5);
    chk("raw_rd",   32'(ram_wen_o), 32'h0);
    tick();
    chk("raw_rv",   32'(rvalid_o), 32'h2);
    chk("raw_data", 32'(rdata_o), 32'h6);

    // Client 1 alone reads 2,1,5 on consecutive cycles.
    we_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: addr_i = {4'h2, 4'h0};
        1: addr_i = {4'h1, 4'h0};
        default: addr_i = {4'h5, 4'h0};
      endcase
      #1;
      chk("c1_gnt", 32'(gnt_o), 32'h2);
      tick();
      chk("c1_rv", 32'(rvalid_o), 32'h2);
      case (i)
        0: chk("c1_data", 32'(rdata_o), 32'hC);
        1: chk("c1_data", 32'(rdata_o), 32'h3);
        default: chk("c1_data", 32'(rdata_o), 32'h6);
      endcase
    end
    req_i = 2'b00;
    #1;
    chk("idle_gnt",  32'(gnt_o), 32'h0);
    chk("idle_addr", 32'(ram_addr_o), 32'h0);
    chk("idle_wen",  32'(ram_wen_o), 32'h0);
    tick();
    chk("pulse_end", 32'(rvalid_o), 32'h0);
    chk("rd_hold",   32'(rdata_o), 32'h6);

    // Client 0 writes 3<-A then reads 3.
    req_i   = 2'b01;
    we_i    = 2'b01;
    addr_i  = {4'h0, 4'h3};
    wdata_i = {4'h0, 4'hA};
    #1;
    chk("wr_gnt",  32'(gnt_o), 32'h1);
    chk("wr_addr", 32'(ram_addr_o), 32'h3);
    tick();
    chk("wr_norv", 32'(rvalid_o), 32'h0);
    we_i = 2'b00;
    #1;
    chk("rd_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 2'b00;
    chk("rd_rv",   32'(rvalid_o), 32'h1);
    chk("rd_data", 32'(rdata_o), 32'hA);

`ifdef RAM_ARB_INIT_EN
    tick();
    req_i  = 2'b01;
    addr_i = {4'h0, 4'h7};
    #1;
    chk("r7_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 2'b00;
    chk("r7_rv",   32'(rvalid_o), 32'h1);
    chk("r7_data", 32'(rdata_o), 32'h0);
`endif

    // Async reset while an rvalid pulse is showing.
    tick();
    req_i  = 2'b01;
    addr_i = {4'h0, 4'h3};
    #1;
    tick();
    req_i = 2'b00;
    chk("pre_rst_rv", 32'(rvalid_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;

`ifdef RAM_ARB_INIT_EN
    // Interrupt INIT at counter 9, then it must restart from 0.
    for (int i = 0; i < 9; i++) tick();
    chk("mid_cnt", 32'(ram_addr_o), 32'h9);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("initrst");
    tick();
    rst_n  = 1'b1;
    req_i  = 2'b01;
    we_i   = 2'b00;
    addr_i = {4'h0, 4'h7};
    #1;
    wait_init();
    chk("held_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 2'b00;
    chk("held_rv", 32'(rvalid_o), 32'h1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
